// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding and constants for the instruction memory controller.
// Boot ROM length and table exist only when IMEM_BOOT_ROM_EN is defined.
package imem_pkg;

  typedef enum logic [2:0] {
`ifdef IMEM_BOOT_ROM_EN
    ST_BOOT      = 3'd0,
`endif
    ST_WAIT_LOAD = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_LOAD      = 3'd3,
    ST_RUN       = 3'd4
  } imem_state_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

`ifdef IMEM_BOOT_ROM_EN
  localparam int BOOT_LEN = 4;
  localparam int BOOT_IW  = $clog2(BOOT_LEN);

  // MIPS-style encodings: add $2,$3,$4 / sub $2,$3,$4 / lw $2,4($3) / beq $3,$4,2
  function automatic logic [31:0] boot_word(input logic [BOOT_IW-1:0] sel);
    case (sel)
      BOOT_IW'(0): boot_word = 32'h0064_1020;
      BOOT_IW'(1): boot_word = 32'h0064_1022;
      BOOT_IW'(2): boot_word = 32'h8C62_0004;
      default:     boot_word = 32'h1064_0002;
    endcase
  endfunction
`endif

endpackage

// File: rtl/imem_fsm.sv
// imem_fsm: sequencing state register for imem_ctrl; boot counter present with IMEM_BOOT_ROM_EN.
//   state     | meaning
//   BOOT      | copy boot table into words 1..BOOT_LEN, one per cycle
//   WAIT_LOAD | memory empty, waiting for the first loader beat
//   DRAIN     | one bubble between a loader request in RUN and LOAD
//   LOAD      | loader burst in progress
//   RUN       | fetch stage served from memory
module imem_fsm
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ld_accept,
  input  logic               i_ld_last,
  input  logic               i_ld_valid,
`ifdef IMEM_BOOT_ROM_EN
  output logic [BOOT_IW-1:0] o_boot_cnt,
`endif
  output imem_state_e        o_state
);

  imem_state_e r_state;
`ifdef IMEM_BOOT_ROM_EN
  logic [BOOT_IW-1:0] r_boot_cnt;
  assign o_boot_cnt = r_boot_cnt;
`endif

  assign o_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef IMEM_BOOT_ROM_EN
      r_state    <= ST_BOOT;
      r_boot_cnt <= BOOT_IW'(BOOT_LEN - 1);
`else
      r_state    <= ST_WAIT_LOAD;
`endif
    end else begin
      case (r_state)
`ifdef IMEM_BOOT_ROM_EN
        ST_BOOT: begin
          if (r_boot_cnt == '0) r_state <= ST_RUN;
          else                  r_boot_cnt <= r_boot_cnt - 1'b1;
        end
`endif
        ST_WAIT_LOAD: if (i_ld_accept) r_state <= i_ld_last ? ST_RUN : ST_LOAD;
        ST_LOAD:      if (i_ld_accept && i_ld_last) r_state <= ST_RUN;
        ST_RUN:       if (i_ld_valid) r_state <= ST_DRAIN;
        ST_DRAIN:     r_state <= ST_LOAD;
        default:      r_state <= ST_WAIT_LOAD;
      endcase
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: arbitrates loader writes and fetch reads on a single-port instruction memory.
// Defining IMEM_BOOT_ROM_EN adds a boot table preload after reset.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [31:0]              pc,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic                     fetch_stall,
  output logic                     fetch_fault,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  imem_state_e w_state;
  logic        w_load_st;
  logic        w_run_st;
  logic        w_ld_accept;
  logic        w_pc_bad;
  logic        w_fetch_go;
  logic        w_fetch_drop;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        r_fetch_fault;
`ifdef IMEM_BOOT_ROM_EN
  logic [BOOT_IW-1:0] w_boot_cnt;
  logic               w_boot_st;
`endif

  imem_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_ld_accept(w_ld_accept),
    .i_ld_last  (ld_last),
    .i_ld_valid (ld_valid),
`ifdef IMEM_BOOT_ROM_EN
    .o_boot_cnt (w_boot_cnt),
`endif
    .o_state    (w_state)
  );

  // rst gates the handshake outputs so they read as idle while reset is held
  assign w_load_st    = (w_state == ST_WAIT_LOAD) || (w_state == ST_LOAD);
  assign w_run_st     = (w_state == ST_RUN);
  assign ld_ready     = w_load_st && !rst;
  assign w_ld_accept  = ld_valid && ld_ready;
  assign fetch_stall  = !w_run_st || ld_valid || rst;
  assign w_pc_bad     = (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != 32'd0);
  assign w_fetch_go   = w_run_st && fetch_req && !ld_valid && !rst;
  assign w_fetch_drop = w_run_st && fetch_req && ld_valid;
`ifdef IMEM_BOOT_ROM_EN
  assign w_boot_st    = (w_state == ST_BOOT) && !rst;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ld_accept) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end
`ifdef IMEM_BOOT_ROM_EN
    else if (w_boot_st) begin
      mem_we    = 1'b1;
      mem_addr  = AW'(BOOT_LEN) - AW'(w_boot_cnt);
      mem_wdata = boot_word(BOOT_IW'(BOOT_LEN - 1) - w_boot_cnt);
    end
`endif
    else if (w_fetch_go && !w_pc_bad) begin
      mem_addr = pc[2 +: AW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst        <= NOP_WORD;
      r_inst_valid  <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_inst_valid  <= w_fetch_go;
      r_fetch_fault <= w_fetch_go && w_pc_bad;
      if (w_fetch_go)        r_inst <= w_pc_bad ? NOP_WORD : mem_rdata;
      else if (w_fetch_drop) r_inst <= NOP_WORD;
    end
  end

  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: randomized bench for imem_ctrl against a word-array reference memory.
// Boot preload checks are compiled in when IMEM_BOOT_ROM_EN is defined.
`timescale 1ns/1ps
module tb_imem_ctrl;
  localparam int          DEPTH = 32;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          fetch_stall;
  logic          fetch_fault;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int excl_viol = 0;
  bit boot_phase = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] tb_mem  [DEPTH];

  imem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fetch_stall(fetch_stall),
    .fetch_fault(fetch_fault),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr];

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
    if (mem_we === 1'b1 && ld_ready !== 1'b1 && !boot_phase) excl_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic do_beat(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
    int waited = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last; fetch_req = 1'b0;
    #1;
    while (ld_ready !== 1'b1 && waited < 4) begin
      @(posedge clk); #2;
      waited++;
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL beat_ready_timeout addr=%0d got=%b exp=1", a, ld_ready);
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d || fetch_stall !== 1'b1) begin
      failures++;
      $display("FAIL beat_write got we=%b addr=%0d data=%h stall=%b exp we=1 addr=%0d data=%h stall=1",
               mem_we, mem_addr, mem_wdata, fetch_stall, a, d);
    end
    ref_mem[a] = d;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

`ifdef IMEM_BOOT_ROM_EN
  task automatic boot_seq();
    logic [31:0] tbl [4];
    tbl = '{32'h0064_1020, 32'h0064_1022, 32'h8C62_0004, 32'h1064_0002};
    boot_phase = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i + 1) || mem_wdata !== tbl[i] ||
          ld_ready !== 1'b0 || fetch_stall !== 1'b1) begin
        failures++;
        $display("FAIL boot_write%0d got we=%b addr=%0d data=%h rdy=%b stall=%b exp we=1 addr=%0d data=%h rdy=0 stall=1",
                 i, mem_we, mem_addr, mem_wdata, ld_ready, fetch_stall, i + 1, tbl[i]);
      end
      ref_mem[i + 1] = tbl[i];
      @(posedge clk); #1;
    end
    boot_phase = 1'b0;
    #1;
    checks++;
    if (fetch_stall !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL boot_to_run got stall=%b we=%b exp stall=0 we=0", fetch_stall, mem_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boot();
    fetch_req = 1'b1; pc = 32'd4;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    checks++;
    if (inst !== 32'h0064_1020 || inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL boot_fetch got inst=%h v=%b f=%b exp inst=00641020 v=1 f=0", inst, inst_valid, fetch_fault);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b1; ld_addr = AW'(3); ld_data = 32'hDEAD_BEEF; ld_last = 1'b0;
    fetch_req = 1'b1; pc = 32'd8;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({inst, inst_valid, fetch_fault, mem_we, mem_addr, mem_wdata, ld_ready, fetch_stall} !==
        {NOP, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values got inst=%h v=%b f=%b we=%b addr=%0d wd=%h rdy=%b stall=%b exp inst=%h v=0 f=0 we=0 addr=0 wd=0 rdy=0 stall=1",
               inst, inst_valid, fetch_fault, mem_we, mem_addr, mem_wdata, ld_ready, fetch_stall, NOP);
    end
    ld_valid = 1'b0; fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef IMEM_BOOT_ROM_EN
    boot_seq();
`else
    #1;
    checks++;
    if (ld_ready !== 1'b1 || fetch_stall !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait_load got rdy=%b stall=%b we=%b exp rdy=1 stall=1 we=0", ld_ready, fetch_stall, mem_we);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_load();
    int we0;
    logic [31:0] d;
    we0 = we_cnt;
    for (int i = 1; i <= 4; i++) begin
      d = (i == 2) ? 32'h0064_0822 : $urandom();
      do_beat(AW'(i), d, i == 4);
      if (i < 4) begin
        repeat ($urandom_range(0, 2)) begin
          #1;
          checks++;
          if (mem_we !== 1'b0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_idle got we=%b rdy=%b exp we=0 rdy=1", mem_we, ld_ready);
          end
          @(posedge clk); #1;
        end
      end
    end
    #1;
    checks++;
    if (fetch_stall !== 1'b0 || ld_ready !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_to_run got stall=%b rdy=%b v=%b exp stall=0 rdy=0 v=0", fetch_stall, ld_ready, inst_valid);
    end
    checks++;
    if (we_cnt - we0 != 4) begin
      failures++;
      $display("FAIL load_we_pulses got=%0d exp=4", we_cnt - we0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_directed();
    fetch_req = 1'b1; pc = 32'd8;
    #1;
    checks++;
    if (mem_addr !== AW'(2) || mem_we !== 1'b0 || fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL fetch8_addr got addr=%0d we=%b stall=%b exp addr=2 we=0 stall=0", mem_addr, mem_we, fetch_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (inst !== 32'h0064_0822 || inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL fetch8 got inst=%h v=%b f=%b exp inst=00640822 v=1 f=0", inst, inst_valid, fetch_fault);
    end
    pc = 32'd6;
    @(posedge clk); #1;
    checks++;
    if (inst !== NOP || inst_valid !== 1'b1 || fetch_fault !== 1'b1) begin
      failures++;
      $display("FAIL fetch_misaligned got inst=%h v=%b f=%b exp inst=%h v=1 f=1", inst, inst_valid, fetch_fault, NOP);
    end
    pc = 32'd128;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_oob_we got=%b exp=0", mem_we);
    end
    @(posedge clk); #1;
    checks++;
    if (inst !== NOP || inst_valid !== 1'b1 || fetch_fault !== 1'b1) begin
      failures++;
      $display("FAIL fetch_oob got inst=%h v=%b f=%b exp inst=%h v=1 f=1", inst, inst_valid, fetch_fault, NOP);
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (inst !== NOP || inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL fetch_idle got inst=%h v=%b f=%b exp inst=%h v=0 f=0", inst, inst_valid, fetch_fault, NOP);
    end
  endtask

  task automatic test_fetch_random();
    logic [31:0] p;
    logic [31:0] exp_inst;
    logic        exp_v, exp_f, req, bad;
    exp_inst = NOP;
    for (int i = 0; i < 60; i++) begin
      req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       p = 32'($urandom_range(1, 4)) * 4;
        1:       p = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
        2:       begin p = $urandom(); if (p < 32'd128) p = p + 32'd128; end
        default: p = ($urandom_range(0, 1) != 0) ? 32'd128 : 32'd16;
      endcase
      bad = (p % 4 != 0) || (p >= 32'(4 * DEPTH));
      fetch_req = req; pc = p;
      #1;
      checks++;
      if (mem_we !== 1'b0 || fetch_stall !== 1'b0 || (req && !bad && mem_addr !== AW'(p / 4))) begin
        failures++;
        $display("FAIL rand_fetch_req%0d got we=%b stall=%b addr=%0d pc=%h exp we=0 stall=0", i, mem_we, fetch_stall, mem_addr, p);
      end
      if (req) begin
        exp_v = 1'b1; exp_f = bad;
        exp_inst = bad ? NOP : ref_mem[p / 4];
      end else begin
        exp_v = 1'b0; exp_f = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (inst !== exp_inst || inst_valid !== exp_v || fetch_fault !== exp_f) begin
        failures++;
        $display("FAIL rand_fetch%0d pc=%h got inst=%h v=%b f=%b exp inst=%h v=%b f=%b",
                 i, p, inst, inst_valid, fetch_fault, exp_inst, exp_v, exp_f);
      end
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    logic [31:0] d;
    d = $urandom();
    fetch_req = 1'b1; pc = 32'd8;
    ld_valid = 1'b1; ld_addr = AW'(31); ld_data = d; ld_last = 1'b1;
    #1;
    checks++;
    if (fetch_stall !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL drain_req got stall=%b rdy=%b we=%b exp stall=1 rdy=0 we=0", fetch_stall, ld_ready, mem_we);
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || ld_ready !== 1'b0 || fetch_stall !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL drain_cycle got v=%b rdy=%b stall=%b we=%b exp v=0 rdy=0 stall=1 we=0", inst_valid, ld_ready, fetch_stall, mem_we);
    end
    @(posedge clk); #1;
    checks++;
    if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(31) || mem_wdata !== d) begin
      failures++;
      $display("FAIL drain_load got rdy=%b we=%b addr=%0d wd=%h exp rdy=1 we=1 addr=31 wd=%h", ld_ready, mem_we, mem_addr, mem_wdata, d);
    end
    ref_mem[31] = d;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
    fetch_req = 1'b1; pc = 32'd124;
    #1;
    checks++;
    if (fetch_stall !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reload_run got stall=%b v=%b exp stall=0 v=0", fetch_stall, inst_valid);
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    checks++;
    if (inst !== ref_mem[31] || inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL fetch_top_word got inst=%h v=%b f=%b exp inst=%h v=1 f=0", inst, inst_valid, fetch_fault, ref_mem[31]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    do_beat(AW'(5), $urandom(), 1'b0);
    do_beat(AW'(6), $urandom(), 1'b0);
    ld_valid = 1'b1; ld_addr = AW'(7); ld_data = $urandom(); ld_last = 1'b0;
    fetch_req = 1'b1; pc = 32'd20;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({inst, inst_valid, fetch_fault, mem_we, mem_addr, mem_wdata, ld_ready, fetch_stall} !==
        {NOP, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midburst_reset got inst=%h v=%b f=%b we=%b addr=%0d wd=%h rdy=%b stall=%b exp inst=%h v=0 f=0 we=0 addr=0 wd=0 rdy=0 stall=1",
               inst, inst_valid, fetch_fault, mem_we, mem_addr, mem_wdata, ld_ready, fetch_stall, NOP);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; fetch_req = 1'b0; rst = 1'b0;
`ifdef IMEM_BOOT_ROM_EN
    boot_seq();
`else
    #1;
    checks++;
    if (ld_ready !== 1'b1 || fetch_stall !== 1'b1) begin
      failures++;
      $display("FAIL midburst_wait_load got rdy=%b stall=%b exp rdy=1 stall=1", ld_ready, fetch_stall);
    end
    @(posedge clk); #1;
`endif
    do_beat(AW'(7), $urandom(), 1'b1);
    for (int k = 5; k <= 7; k++) begin
      fetch_req = 1'b1; pc = 32'(k * 4);
      @(posedge clk); #1;
      checks++;
      if (inst !== ref_mem[k] || inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin
        failures++;
        $display("FAIL partial_word%0d got inst=%h v=%b exp inst=%h v=1", k, inst, inst_valid, ref_mem[k]);
      end
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_exclusion();
    checks++;
    if (excl_viol != 0) begin
      failures++;
      $display("FAIL write_without_ready got=%0d exp=0", excl_viol);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    test_reset();
`ifdef IMEM_BOOT_ROM_EN
    test_boot();
`endif
    test_load();
    test_fetch_directed();
    test_fetch_random();
    test_drain();
    test_reset_mid_burst();
    test_write_exclusion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, word returned on faulted or flushed fetch.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  input  1  fetch stage requests instruction at pc.
REQ-006 pc  input  32  byte address of requested instruction.
REQ-007 inst  output  32  fetched instruction, registered.
REQ-008 inst_valid  output  1  inst holds a fresh fetch result.
REQ-009 fetch_stall  output  1  fetch stage shall hold pc.
REQ-010 fetch_fault  output  1  one-cycle pulse, misaligned or out-of-range pc.
REQ-011 ld_valid, ld_ready  input/output  1 each  loader write handshake.
REQ-012 ld_addr  input  $clog2(DEPTH)  loader word index.
REQ-013 ld_data  input  32  loader word.
REQ-014 ld_last  input  1  final beat of a load burst.
REQ-015 mem_we  output  1  memory write strobe.
REQ-016 mem_addr  output  $clog2(DEPTH)  memory word index.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory combinational read data for mem_addr.

Function
REQ-019 States BOOT, WAIT_LOAD, DRAIN, LOAD, RUN; state register only changes on clk or rst.
REQ-020 WAIT_LOAD/LOAD: ld_ready=1, fetch_stall=1; beat accepted when ld_valid&&ld_ready, drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle.
REQ-021 WAIT_LOAD -> LOAD on first accepted beat without ld_last; any accepted beat with ld_last -> RUN next cycle.
REQ-022 RUN: fetch_stall=0, ld_ready=0; fetch_req drives mem_addr=pc[2+:$clog2(DEPTH)], mem_we=0; inst<=mem_rdata and inst_valid=1 on next cycle (latency 1).
REQ-023 RUN cycle without fetch_req: inst holds, inst_valid=0.
REQ-024 pc[1:0]!=0 or pc>=4*DEPTH with fetch_req in RUN: inst<=NOP_WORD, inst_valid=1, fetch_fault=1 next cycle; no memory read.
REQ-025 ld_valid in RUN: loader has priority; -> DRAIN, fetch_stall=1 from that cycle, that cycle's fetch_req discarded.
REQ-026 DRAIN lasts exactly one cycle, inst_valid=0, ld_ready=0, then -> LOAD.
REQ-027 Entering RUN from LOAD: first inst_valid no earlier than 2 cycles after ld_last accept.
REQ-028 Loader writes never coincide with a fetch read; mem_we=0 whenever ld_ready=0.

Reset
REQ-029 rst asserted: inst=NOP_WORD, inst_valid=0, fetch_fault=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_ready=0, fetch_stall=1.
REQ-030 Reset state BOOT with IMEM_BOOT_ROM_EN, else WAIT_LOAD; rst mid-burst abandons burst, partial writes stay in memory.

Configuration
REQ-031 Macro IMEM_BOOT_ROM_EN defined: BOOT writes BOOT_LEN package words to indices 1..BOOT_LEN, one per cycle, ld_ready=0, then -> RUN.
REQ-032 IMEM_BOOT_ROM_EN undefined: BOOT state and table absent; memory content comes only from loader.

Structure
REQ-033 Package imem_pkg holds state enum, NOP_WORD default, BOOT_LEN=4 and boot table (add, sub, lw, beq encodings).
REQ-034 Sub-module imem_fsm holds state register and transitions; datapath muxing stays in imem_ctrl.

Verification
REQ-035 Load 4 beats idx1..4, ld_last on 4th -> 4 mem_we pulses, RUN, fetch_stall=0 next cycle.
REQ-036 RUN, pc=8 with mem[2]=32'h0064_0822 -> inst=32'h0064_0822, inst_valid=1 one cycle later.
REQ-037 RUN, pc=6 then pc=128 -> each gives inst=NOP_WORD, fetch_fault=1 pulse, no mem read.
REQ-038 ld_valid raised in RUN with fetch_req -> fetch discarded, DRAIN 1 cycle, ld_ready=1 in LOAD.
REQ-039 rst pulsed mid-burst after beat 2 -> outputs reset values, state WAIT_LOAD (or BOOT).
REQ-040 IMEM_BOOT_ROM_EN defined, no loader -> 4 boot writes then pc=4 returns 32'h0064_1020.
